// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int HZ_REG_W = 3;
    localparam int HZ_CNT_W = 16;

    // EX operand mux select encodings.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_WB = 2'b01,
        FWD_EX = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        HOLD     = 2'b10
    } hz_state_t;

    // Shadow copy of one pipeline slot. The mem/wb slots only rely on
    // valid, rd and regwrite; the remaining fields ride along unchanged.
    typedef struct packed {
        logic                valid;
        logic [HZ_REG_W-1:0] rd;
        logic                regwrite;
        logic                memread;
        fwd_sel_t            fa;
        fwd_sel_t            fb;
    } shadow_slot_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding select for one EX source operand, matched against the
// pre-advance ex and mem shadow slots.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [HZ_REG_W-1:0] rs,
    input  logic                src_use,
    input  shadow_slot_t        ex_slot,
    input  shadow_slot_t        mem_slot,
    output fwd_sel_t            sel
);

    // Nearest producer wins; loads in ex are handled by the stall path instead.
    always_comb begin
        sel = FWD_RF;
        if (src_use && (rs != '0)) begin
            if (ex_slot.valid && ex_slot.regwrite && !ex_slot.memread && (ex_slot.rd == rs)) begin
                sel = FWD_EX;
            end else if (mem_slot.valid && mem_slot.regwrite && (mem_slot.rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadow ID/EX, EX/MEM, MEM/WB slots, forwarding
// selects, load-use stall, branch flush, memory-busy hold and event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = HZ_REG_W,
    parameter int CNT_W = HZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic [1:0]       fa,
    output logic [1:0]       fb,
    output logic             pc_hold,
    output logic             idex_bubble,
    output logic             flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t        state_q, state_d;
    shadow_slot_t     ex_q, ex_d;
    shadow_slot_t     mem_q, mem_d;
    shadow_slot_t     wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    fwd_sel_t id_fa, id_fb;
    logic     adv;
    logic     load_use;
    logic     do_flush;
    logic     do_stall;

    // An invalid ID instruction must enter ex with both selects at register file.
    fwd_select u_fwd_a (
        .rs       (id_rs1),
        .src_use  (id_use_rs1 & id_valid),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .sel      (id_fa)
    );

    fwd_select u_fwd_b (
        .rs       (id_rs2),
        .src_use  (id_use_rs2 & id_valid),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .sel      (id_fb)
    );

    // Hazard priority: memory busy, then taken branch, then load-use, then advance.
    always_comb begin
        adv      = !mem_busy;
        load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                   ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));
        do_flush = adv && ex_branch_taken;
        do_stall = adv && !ex_branch_taken && load_use;

        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!adv) begin
            state_d = HOLD;
        end else begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (do_flush || do_stall) begin
                ex_d = '0;
            end else begin
                ex_d.valid    = id_valid;
                ex_d.rd       = id_rd;
                ex_d.regwrite = id_regwrite & id_valid;
                ex_d.memread  = id_memread & id_valid;
                ex_d.fa       = id_fa;
                ex_d.fb       = id_fb;
            end
            state_d = do_stall ? LU_STALL : RUN;
            if (do_stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (do_flush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // Shadow slots, FSM state and counters; async reset clears a pending stall at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fa          = ex_q.fa;
    assign fb          = ex_q.fb;
    assign pc_hold     = do_stall & rst_n;
    assign idex_bubble = do_stall & rst_n;
    assign flush       = do_flush & rst_n;
    assign pipe_hold   = mem_busy & rst_n;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected EX selects are queued when an
// ID instruction is driven and compared once the clock edge moves it into EX.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs1;
    logic [2:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [2:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        ex_branch_taken;
    logic        mem_busy;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pc_hold;
    logic        idex_bubble;
    logic        flush;
    logic        pipe_hold;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    typedef struct {
        string      tag;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    hazard_ctrl #(.REG_W(3), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .fa              (fa),
        .fb              (fb),
        .pc_hold         (pc_hold),
        .idex_bubble     (idex_bubble),
        .flush           (flush),
        .pipe_hold       (pipe_hold),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one ID-stage cycle, check the combinational requests and counters,
    // and queue the selects EX must show after the coming edge.
    task automatic applyStimulus(input string tag, input logic v,
                                 input logic [2:0] rd, input logic [2:0] rs1, input logic u1,
                                 input logic [2:0] rs2, input logic u2,
                                 input logic rw, input logic mr, input logic br, input logic busy,
                                 input logic [1:0] exp_fa, input logic [1:0] exp_fb,
                                 input logic exp_ph, input logic exp_bub, input logic exp_fl,
                                 input int exp_sc, input int exp_fc);
        exp_t e;
        @(negedge clk);
        id_valid        = v;
        id_rd           = rd;
        id_rs1          = rs1;
        id_use_rs1      = u1;
        id_rs2          = rs2;
        id_use_rs2      = u2;
        id_regwrite     = rw;
        id_memread      = mr;
        ex_branch_taken = br;
        mem_busy        = busy;
        #1;
        checkOutput({tag, "_pc_hold"}, 32'(pc_hold), 32'(exp_ph));
        checkOutput({tag, "_bubble"}, 32'(idex_bubble), 32'(exp_bub));
        checkOutput({tag, "_flush"}, 32'(flush), 32'(exp_fl));
        checkOutput({tag, "_pipe_hold"}, 32'(pipe_hold), 32'(busy));
        checkOutput({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_sc));
        checkOutput({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_fc));
        e.tag = tag;
        e.fa  = exp_fa;
        e.fb  = exp_fb;
        exp_q.push_back(e);
    endtask

    // Pop the expected EX selects just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput({e.tag, "_fa"}, 32'(fa), 32'(e.fa));
            checkOutput({e.tag, "_fb"}, 32'(fb), 32'(e.fb));
        end
    end

    // Bound the run so a stuck design still reaches a verdict.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] timeout");
    end

    // Directed sequence walking through each hazard scenario.
    initial begin
        rst_n           = 1'b0;
        id_valid        = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_use_rs1      = 1'b0;
        id_use_rs2      = 1'b0;
        id_rd           = '0;
        id_regwrite     = 1'b0;
        id_memread      = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
        #12;
        checkOutput("rst_fa", 32'(fa), 32'd0);
        checkOutput("rst_fb", 32'(fb), 32'd0);
        checkOutput("rst_pc_hold", 32'(pc_hold), 32'd0);
        checkOutput("rst_bubble", 32'(idex_bubble), 32'd0);
        checkOutput("rst_flush", 32'(flush), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //              tag       v  rd    rs1  u1 rs2  u2 rw mr br bsy  fa fb ph bb fl sc fc
        applyStimulus("add_r1",  1, 3'd1, 3'd4, 1, 3'd5, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus("sub_r1",  1, 3'd6, 3'd1, 1, 3'd7, 1, 1, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus("add_r2",  1, 3'd2, 3'd0, 1, 3'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus("or_r5",   1, 3'd5, 3'd4, 1, 3'd3, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus("and_r2",  1, 3'd7, 3'd1, 1, 3'd2, 1, 1, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 0, 0);
        applyStimulus("lw_r3",   1, 3'd3, 3'd4, 1, 3'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        applyStimulus("lu_stall",1, 3'd4, 3'd3, 1, 3'd1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 1, 1, 0, 0, 0);
        applyStimulus("lu_retry",1, 3'd4, 3'd3, 1, 3'd1, 1, 1, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 1, 0);
        applyStimulus("lw_r0",   1, 3'd0, 3'd5, 1, 3'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0);
        applyStimulus("rd_r0_ld",1, 3'd6, 3'd0, 1, 3'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0);
        applyStimulus("add_r0",  1, 3'd0, 3'd1, 1, 3'd0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0);
        applyStimulus("rd_r0_al",1, 3'd1, 3'd0, 1, 3'd6, 1, 1, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 1, 0);
        applyStimulus("lw_r2",   1, 3'd2, 3'd0, 1, 3'd0, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0);
        applyStimulus("br_lu",   1, 3'd3, 3'd2, 1, 3'd0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 1, 1, 0);
        applyStimulus("after_br",1, 3'd5, 3'd2, 1, 3'd4, 1, 1, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 1, 1);
        applyStimulus("hold1",   1, 3'd6, 3'd5, 1, 3'd0, 0, 1, 0, 0, 1, 2'd1, 2'd0, 0, 0, 0, 1, 1);
        applyStimulus("hold2",   1, 3'd6, 3'd5, 1, 3'd0, 0, 1, 0, 0, 1, 2'd1, 2'd0, 0, 0, 0, 1, 1);
        applyStimulus("hold3",   1, 3'd6, 3'd5, 1, 3'd0, 0, 1, 0, 0, 1, 2'd1, 2'd0, 0, 0, 0, 1, 1);

        // Reset in the middle of a memory hold clears everything at once.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_fa", 32'(fa), 32'd0);
        checkOutput("midrst_fb", 32'(fb), 32'd0);
        checkOutput("midrst_pc_hold", 32'(pc_hold), 32'd0);
        checkOutput("midrst_bubble", 32'(idex_bubble), 32'd0);
        checkOutput("midrst_flush", 32'(flush), 32'd0);
        checkOutput("midrst_pipe_hold", 32'(pipe_hold), 32'd0);
        checkOutput("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("midrst_flush_cnt", 32'(flush_cnt), 32'd0);

        @(posedge clk);
        #3;
        checkOutput("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
